// File: rtl/bidir_link_pkg.sv
// Shared types and default constants for the bidirectional single-wire link controller.
package bidir_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    TURN = 2'd2,
    RX   = 2'd3
  } link_state_t;

  localparam int DATA_W_DEF = 8;
  localparam int TURN_DEF   = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bidir_link_ctrl_if.sv
// Host handshake plus IO_BUF pad signals of the link controller, bundled as one port.
import bidir_link_pkg::*;

interface bidir_link_ctrl_if #(
  parameter int DATA_W = DATA_W_DEF
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              pad_i;
  logic              pad_o;
  logic              pad_t;

  modport slave (
    input  tx_valid, tx_data, pad_i,
    output tx_ready, rx_valid, rx_data, busy, pad_o, pad_t
  );

  modport master (
    output tx_valid, tx_data, pad_i,
    input  tx_ready, rx_valid, rx_data, busy, pad_o, pad_t
  );
endinterface

// File: rtl/link_shift_reg.sv
// Shift register shared by transmit and receive: parallel load, shifts toward the MSB
// with the new bit entering at the LSB.
module link_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  input  logic              shift_in,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= load_data;
    else if (shift)
      q <= {q[DATA_W-2:0], shift_in};
  end

endmodule

// File: rtl/bidir_link_ctrl.sv
// Half-duplex link controller: sends a word MSB-first, turns the bus around,
// then receives a response word MSB-first. Pad buffers live in the parent.
import bidir_link_pkg::*;

module bidir_link_ctrl #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TURN_CYCLES = TURN_DEF
) (
  input logic             clk,
  input logic             reset,
  bidir_link_ctrl_if.slave link
);

  localparam int CNT_W = $clog2(max_int(DATA_W, TURN_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_TURN = CNT_W'(TURN_CYCLES - 1);

  link_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] rx_data_q, rx_data_nxt;
  logic              sr_load, sr_shift, sr_in;
  logic              pad_o_q, pad_o_nxt;
  logic              pad_t_q, pad_t_nxt;
  logic              rx_valid_q, rx_valid_nxt;
  logic              tx_ready_q, tx_ready_nxt;

  link_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (sr_load),
    .load_data (link.tx_data),
    .shift     (sr_shift),
    .shift_in  (sr_in),
    .q         (sr_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rx_data_q  <= '0;
      pad_o_q    <= 1'b0;
      pad_t_q    <= 1'b1;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rx_data_q  <= rx_data_nxt;
      pad_o_q    <= pad_o_nxt;
      pad_t_q    <= pad_t_nxt;
      rx_valid_q <= rx_valid_nxt;
      tx_ready_q <= tx_ready_nxt;
    end
  end

  // Pad and handshake outputs are precomputed for the next state so they leave flops.
  always_comb begin
    state_nxt    = state;
    rx_data_nxt  = rx_data_q;
    pad_o_nxt    = 1'b0;
    rx_valid_nxt = 1'b0;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    sr_in        = 1'b0;
    case (state)
      IDLE: begin
        if (link.tx_valid && tx_ready_q) begin
          state_nxt = TX;
          sr_load   = 1'b1;
          pad_o_nxt = link.tx_data[DATA_W-1];
        end
      end
      TX: begin
        sr_shift = 1'b1;
        if (cnt == LAST_BIT)
          state_nxt = TURN;
        else
          pad_o_nxt = sr_q[DATA_W-2];
      end
      TURN: begin
        if (cnt == LAST_TURN)
          state_nxt = RX;
      end
      RX: begin
        sr_shift = 1'b1;
        sr_in    = link.pad_i;
        if (cnt == LAST_BIT) begin
          state_nxt    = IDLE;
          rx_valid_nxt = 1'b1;
          rx_data_nxt  = {sr_q[DATA_W-2:0], link.pad_i};
        end
      end
      default: state_nxt = IDLE;
    endcase
    cnt_nxt      = (state_nxt != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
    pad_t_nxt    = (state_nxt != TX);
    tx_ready_nxt = (state_nxt == IDLE);
  end

  assign link.pad_o    = pad_o_q;
  assign link.pad_t    = pad_t_q;
  assign link.rx_valid = rx_valid_q;
  assign link.rx_data  = rx_data_q;
  assign link.tx_ready = tx_ready_q;
  assign link.busy     = (state != IDLE);

endmodule

// File: tb/tb_bidir_link_ctrl.sv
// Directed bench for bidir_link_ctrl: an 8-bit/2-turn instance and a 4-bit/1-turn instance.
module tb_bidir_link_ctrl;
  import bidir_link_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic prev_rv8 = 1'b0;
  logic prev_rv4 = 1'b0;

  always #5 clk = ~clk;

  bidir_link_ctrl_if #(.DATA_W(8)) l8 ();
  bidir_link_ctrl_if #(.DATA_W(4)) l4 ();

  bidir_link_ctrl #(.DATA_W(8), .TURN_CYCLES(2)) dut8 (.clk(clk), .reset(reset), .link(l8.slave));
  bidir_link_ctrl #(.DATA_W(4), .TURN_CYCLES(1)) dut4 (.clk(clk), .reset(reset), .link(l4.slave));

  // Advance one cycle and check the always-true properties of both instances.
  task automatic step();
    @(posedge clk);
    #1;
    n_cmp++;
    if (l8.pad_t === 1'b0 && dut8.state !== TX) begin
      n_fail++;
      $display("[TB] FAIL pad_t_outside_tx8: pad_t=%b state=%0d, required state %0d", l8.pad_t, dut8.state, TX);
    end
    n_cmp++;
    if (l4.pad_t === 1'b0 && dut4.state !== TX) begin
      n_fail++;
      $display("[TB] FAIL pad_t_outside_tx4: pad_t=%b state=%0d, required state %0d", l4.pad_t, dut4.state, TX);
    end
    n_cmp++;
    if (prev_rv8 === 1'b1 && l8.rx_valid === 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rx_valid_double8: rx_valid=1 two cycles running, required single pulse");
    end
    n_cmp++;
    if (prev_rv4 === 1'b1 && l4.rx_valid === 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rx_valid_double4: rx_valid=1 two cycles running, required single pulse");
    end
    prev_rv8 = l8.rx_valid;
    prev_rv4 = l4.rx_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    l8.tx_valid = 1'b0; l8.tx_data = 8'h00; l8.pad_i = 1'b0;
    l4.tx_valid = 1'b0; l4.tx_data = 4'h0;  l4.pad_i = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({l8.pad_t, l8.pad_o, l8.rx_valid, l8.busy, l8.tx_ready} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: {pad_t,pad_o,rx_valid,busy,tx_ready}=%b, required 10000",
               {l8.pad_t, l8.pad_o, l8.rx_valid, l8.busy, l8.tx_ready});
    end
    n_cmp++;
    if (l8.rx_data !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_rx_data: got %h, required 00", l8.rx_data);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({l8.tx_ready, l8.busy, l8.pad_t} !== 3'b101) begin
      n_fail++;
      $display("[TB] FAIL reset_release: {tx_ready,busy,pad_t}=%b, required 101", {l8.tx_ready, l8.busy, l8.pad_t});
    end
  endtask

  task automatic test_tx_rx(input logic [7:0] tx, input logic [7:0] rx);
    int pulses = 0;
    int rise_at = -1;
    l8.tx_data = tx;
    l8.tx_valid = 1'b1;
    step();
    l8.tx_valid = 1'b0;
    l8.tx_data = ~tx;
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (c < 8) begin
        if ({l8.pad_t, l8.pad_o} !== {1'b0, tx[7-c]}) begin
          n_fail++;
          $display("[TB] FAIL tx_bit%0d: {pad_t,pad_o}=%b, required %b", c, {l8.pad_t, l8.pad_o}, {1'b0, tx[7-c]});
        end
      end else if (c < 10) begin
        if ({l8.pad_t, l8.pad_o} !== 2'b10) begin
          n_fail++;
          $display("[TB] FAIL turn_c%0d: {pad_t,pad_o}=%b, required 10", c, {l8.pad_t, l8.pad_o});
        end
      end else if (l8.pad_t !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL rx_pad_t_c%0d: pad_t=%b, required 1", c, l8.pad_t);
      end
      if (c == 3) begin
        n_cmp++;
        if ({l8.busy, l8.tx_ready} !== 2'b10) begin
          n_fail++;
          $display("[TB] FAIL tx_busy: {busy,tx_ready}=%b, required 10", {l8.busy, l8.tx_ready});
        end
      end
      if (l8.rx_valid === 1'b1) begin
        pulses++;
        if (rise_at < 0) rise_at = c;
      end
      l8.pad_i = (c >= 10 && c < 18) ? rx[17-c] : 1'b1;
      if (c < 19) step();
    end
    n_cmp++;
    if (pulses != 1 || rise_at != 18) begin
      n_fail++;
      $display("[TB] FAIL rx_pulse: pulses=%0d rise=%0d, required 1 pulse at 18", pulses, rise_at);
    end
    n_cmp++;
    if (l8.rx_data !== rx) begin
      n_fail++;
      $display("[TB] FAIL rx_data: got %h, required %h", l8.rx_data, rx);
    end
    n_cmp++;
    if ({l8.tx_ready, l8.busy} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL rx_idle: {tx_ready,busy}=%b, required 10", {l8.tx_ready, l8.busy});
    end
  endtask

  task automatic test_back_to_back();
    l8.tx_data = 8'h5A;
    l8.tx_valid = 1'b1;
    l8.pad_i = 1'b1;
    step();
    l8.tx_data = 8'hC3;
    for (int c = 0; c < 38; c++) begin
      if (c == 0 || c == 19 || c == 20 || c == 21) begin
        n_cmp++;
        if ({l8.pad_t, l8.pad_o, l8.busy} !== {1'b0, (c == 0) ? 1'b0 : (c == 21) ? 1'b0 : 1'b1, 1'b1}) begin
          n_fail++;
          $display("[TB] FAIL b2b_tx_c%0d: {pad_t,pad_o,busy}=%b", c, {l8.pad_t, l8.pad_o, l8.busy});
        end
      end
      if (c == 1) begin
        n_cmp++;
        if (l8.tx_ready !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL b2b_ready_busy: tx_ready=%b, required 0", l8.tx_ready);
        end
      end
      if (c == 8 || c == 9 || c == 27 || c == 28) begin
        n_cmp++;
        if (l8.pad_t !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL b2b_turn_c%0d: pad_t=%b, required 1", c, l8.pad_t);
        end
      end
      if (c == 18) begin
        n_cmp++;
        if ({l8.rx_valid, l8.busy, l8.tx_ready, l8.rx_data} !== {3'b101, 8'hFF}) begin
          n_fail++;
          $display("[TB] FAIL b2b_gap: {rx_valid,busy,tx_ready,rx_data}=%b_%h, required 101_ff",
                   {l8.rx_valid, l8.busy, l8.tx_ready}, l8.rx_data);
        end
      end
      if (c == 19) begin
        l8.tx_valid = 1'b0;
        l8.pad_i = 1'b0;
      end
      if (c == 30) begin
        n_cmp++;
        if (l8.rx_data !== 8'hFF) begin
          n_fail++;
          $display("[TB] FAIL b2b_hold: rx_data=%h, required ff", l8.rx_data);
        end
      end
      if (c == 37) begin
        n_cmp++;
        if ({l8.rx_valid, l8.rx_data} !== {1'b1, 8'h00}) begin
          n_fail++;
          $display("[TB] FAIL b2b_second_rx: {rx_valid,rx_data}=%b_%h, required 1_00", l8.rx_valid, l8.rx_data);
        end
      end
      if (c < 37) step();
    end
    step();
  endtask

  task automatic test_reset_mid_tx();
    int pulses = 0;
    l8.tx_data = 8'h96;
    l8.tx_valid = 1'b1;
    step();
    l8.tx_valid = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (l8.pad_t !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_pre: pad_t=%b, required 0", l8.pad_t);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({l8.pad_t, l8.pad_o, l8.busy, l8.tx_ready, l8.rx_valid} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL abort_async: {pad_t,pad_o,busy,tx_ready,rx_valid}=%b, required 10000",
               {l8.pad_t, l8.pad_o, l8.busy, l8.tx_ready, l8.rx_valid});
    end
    repeat (2) step();
    reset = 1'b0;
    step();
    n_cmp++;
    if (l8.tx_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort_ready: tx_ready=%b, required 1", l8.tx_ready);
    end
    for (int i = 0; i < 25; i++) begin
      if (l8.rx_valid === 1'b1) pulses++;
      step();
    end
    n_cmp++;
    if (pulses != 0 || l8.busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_rx: pulses=%0d busy=%b, required 0 and 0", pulses, l8.busy);
    end
  endtask

  task automatic test_small(input logic [3:0] tx, input logic [3:0] rx);
    int pulses = 0;
    int rise_at = -1;
    l4.tx_data = tx;
    l4.tx_valid = 1'b1;
    step();
    l4.tx_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c < 4) begin
        n_cmp++;
        if ({l4.pad_t, l4.pad_o} !== {1'b0, tx[3-c]}) begin
          n_fail++;
          $display("[TB] FAIL small_tx_bit%0d: {pad_t,pad_o}=%b, required %b", c, {l4.pad_t, l4.pad_o}, {1'b0, tx[3-c]});
        end
      end else if (c == 4) begin
        n_cmp++;
        if ({l4.pad_t, l4.pad_o} !== 2'b10) begin
          n_fail++;
          $display("[TB] FAIL small_turn: {pad_t,pad_o}=%b, required 10", {l4.pad_t, l4.pad_o});
        end
      end
      if (l4.rx_valid === 1'b1) begin
        pulses++;
        if (rise_at < 0) rise_at = c;
      end
      l4.pad_i = (c >= 5 && c < 9) ? rx[8-c] : 1'b0;
      if (c == 9) begin
        n_cmp++;
        if (l4.rx_data !== rx) begin
          n_fail++;
          $display("[TB] FAIL small_rx_data: got %h, required %h", l4.rx_data, rx);
        end
      end
      if (c < 10) step();
    end
    n_cmp++;
    if (pulses != 1 || rise_at != 9) begin
      n_fail++;
      $display("[TB] FAIL small_rx_pulse: pulses=%0d rise=%0d, required 1 pulse at 9", pulses, rise_at);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_tx_rx(8'hA5, 8'h3C);
    test_back_to_back();
    test_reset_mid_tx();
    test_small(4'h9, 4'h6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bidir_link_ctrl.md
BIDIR_LINK_CTRL -- requirements
Module: bidir_link_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits; legal range 2..32.
REQ-002 Parameter TURN_CYCLES, default 2, bus-turnaround idle cycles; legal range 1..15.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 tx_valid  input  1  host word available.
REQ-006 tx_data  input  DATA_W  host word, MSB sent first.
REQ-007 tx_ready  output  1  block can accept a word.
REQ-008 rx_valid  output  1  one-cycle pulse, response word ready.
REQ-009 rx_data  output  DATA_W  received response word.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 pad_i  input  1  receive bit from the IO_BUF O pin.
REQ-012 pad_o  output  1  transmit bit to the IO_BUF I pin.
REQ-013 pad_t  output  1  IO_BUF T pin; 1 = high-Z/receive, 0 = drive.

Function
REQ-014 The FSM SHALL have the states IDLE, TX, TURN and RX only.
REQ-015 In IDLE, tx_ready SHALL be 1, pad_t SHALL be 1 and pad_o SHALL be 0; tx_ready SHALL be 0 in every other state.
REQ-016 A word SHALL be accepted on a rising edge where tx_valid=1 and tx_ready=1; that edge SHALL load tx_data into the shift register and enter TX.
REQ-017 TX SHALL last DATA_W cycles with pad_t=0; pad_o SHALL present tx_data[DATA_W-1] in the first cycle, then one lower bit per cycle.
REQ-018 After the last TX cycle, the FSM SHALL enter TURN for TURN_CYCLES cycles with pad_t=1 and pad_o=0.
REQ-019 After TURN, the FSM SHALL enter RX for DATA_W cycles with pad_t=1, sampling pad_i on the rising edge that ends each RX cycle, MSB first.
REQ-020 The edge that takes the final RX sample SHALL update rx_data, pulse rx_valid high for exactly one cycle and return the FSM to IDLE.
REQ-021 rx_data SHALL hold its value until the next rx_valid pulse.
REQ-022 rx_valid SHALL rise DATA_W+TURN_CYCLES+DATA_W cycles after the accept edge (18 cycles at the defaults).
REQ-023 If tx_valid=1 in the rx_valid cycle, that word SHALL be accepted on the following edge, because tx_ready=1 in that cycle.
REQ-024 tx_valid SHALL be ignored while busy=1, and tx_data SHALL be sampled only on the accept edge.
REQ-025 pad_t, pad_o, rx_valid and tx_ready SHALL all be driven directly from flops (registered, no combinational path from inputs).
REQ-026 pad_t SHALL never be 0 in any cycle where the FSM is not in TX.
REQ-027 The bit counter SHALL be ceil(log2(max(DATA_W,TURN_CYCLES))+1) bits wide and SHALL reload to 0 on each state change.

Reset
REQ-028 On reset assertion, the block SHALL immediately (asynchronously) force: state=IDLE, pad_t=1, pad_o=0, rx_valid=0, busy=0, rx_data=0, shift register=0, counter=0.
REQ-029 Reset asserted mid-TX or mid-RX SHALL abort the transfer with no rx_valid pulse.
REQ-030 tx_ready SHALL be 0 while reset is asserted and SHALL become 1 in the first cycle after deassertion.

Structure
REQ-031 Package bidir_link_pkg SHALL hold the state enum (IDLE, TX, TURN, RX) and the default constants DATA_W_DEF=8 and TURN_DEF=2.
REQ-032 A sub-module link_shift_reg SHALL provide the shared DATA_W shift register, with parallel load, shift-out MSB and shift-in LSB.
REQ-033 The block SHALL instantiate no pad primitives; IO_BUF instantiation SHALL be done by the parent.

Verification
REQ-034 Scenario: reset, then tx_data=0xA5 with tx_valid=1 -> pad_o sequence 1,0,1,0,0,1,0,1 with pad_t=0 for exactly 8 cycles, then pad_t=1.
REQ-035 Scenario: pad_i driven with 0x3C MSB-first during RX -> rx_data=0x3C with a single rx_valid pulse 18 cycles after the accept edge.
REQ-036 Scenario: tx_valid held high continuously -> back-to-back transfers with exactly one IDLE cycle between them, and pad_t=1 throughout each TURN.
REQ-037 Scenario: reset pulsed at TX bit 3 -> pad_t=1 in the same cycle, no rx_valid pulse, and tx_ready=1 one cycle after release.
REQ-038 Scenario: TURN_CYCLES=1, DATA_W=4, tx=0x9, pad_i=0x6 -> rx_data=0x6, rx_valid rises 9 cycles after accept.
REQ-039 Assertion for all scenarios: pad_t=0 only while the FSM is in TX, and rx_valid is never high for two consecutive cycles.
